collision_detector: RTL

Per-pixel collision detector that sits directly downstream of the background stage and the object drawing stages. It samples the draw-request strobes for every pixel, including the background's `boardersDrawReq`, and detects overlaps between game objects and the zone borders. Each collision type is reported as a single-cycle pulse at most once per frame, and a registered per-frame summary is kept for the game controller.

---
 rtl/game_pkg.sv | 17 +
 rtl/collision_event_latch.sv | 36 +++
 rtl/collision_detector.sv | 67 ++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: collision event indices and background border bit positions.
package game_pkg;

  localparam int NUM_COLLISIONS      = 5;

  localparam int COL_PLAYER_HIT      = 0;
  localparam int COL_ENEMY_HIT       = 1;
  localparam int COL_PLAYER_BORDER   = 2;
  localparam int COL_ENEMY_BORDER    = 3;
  localparam int COL_ZONE_BREACH     = 4;

  localparam int BOARDER_SIDE        = 0;
  localparam int BOARDER_PLAYER_ZONE = 1;

  typedef logic [NUM_COLLISIONS-1:0] collision_vec_t;

endpackage

// File: rtl/collision_event_latch.sv
// Per-event first-hit-per-frame detector: one-cycle pulse on the first hit of a frame,
// plus an accumulated flag published at each startOfFrame.
module collision_event_latch (
  input  logic clk,
  input  logic resetN,
  input  logic hit,
  input  logic startOfFrame,
  output logic pulse,
  output logic frame_seen
);

  logic r_fired;
  logic r_accum;

  // A hit in the startOfFrame cycle belongs to the new frame, not the published one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fired    <= 1'b0;
      r_accum    <= 1'b0;
      pulse      <= 1'b0;
      frame_seen <= 1'b0;
    end else if (startOfFrame) begin
      frame_seen <= r_accum;
      r_fired    <= hit;
      r_accum    <= hit;
      pulse      <= hit;
    end else begin
      pulse <= hit & ~r_fired;
      if (hit) begin
        r_fired <= 1'b1;
        r_accum <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Per-pixel collision detector: coincidence equations, per-event frame latches and a
// saturating count of frames that contained an enemy hit.
module collision_detector
  import game_pkg::*;
#(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   collision_enable,
  input  logic                   playerDrawReq,
  input  logic                   enemiesDrawReq,
  input  logic                   playerMissileDrawReq,
  input  logic                   enemyMissileDrawReq,
  input  logic [1:0]             boardersDrawReq,
  input  logic                   clear_count,
  output logic [4:0]             collision_pulses,
  output logic [4:0]             frame_collisions,
  output logic [COUNT_WIDTH-1:0] enemy_hit_count
);

  collision_vec_t w_raw;
  collision_vec_t w_hit;
  logic           w_enemy_new;
  logic           r_enemy_counted;

  always_comb begin
    w_raw                    = '0;
    w_raw[COL_PLAYER_HIT]    = playerDrawReq & (enemyMissileDrawReq | enemiesDrawReq);
    w_raw[COL_ENEMY_HIT]     = playerMissileDrawReq & enemiesDrawReq;
    w_raw[COL_PLAYER_BORDER] = playerDrawReq & boardersDrawReq[BOARDER_SIDE];
    w_raw[COL_ENEMY_BORDER]  = enemiesDrawReq & boardersDrawReq[BOARDER_SIDE];
    w_raw[COL_ZONE_BREACH]   = enemiesDrawReq & boardersDrawReq[BOARDER_PLAYER_ZONE];
  end

  assign w_hit = w_raw & {NUM_COLLISIONS{collision_enable}};

  for (genvar g = 0; g < NUM_COLLISIONS; g++) begin : g_event
    collision_event_latch u_latch (
      .clk          (clk),
      .resetN       (resetN),
      .hit          (w_hit[g]),
      .startOfFrame (startOfFrame),
      .pulse        (collision_pulses[g]),
      .frame_seen   (frame_collisions[g])
    );
  end

  // Local copy of the ENEMY_HIT fired flag so the count lands in the same cycle as the pulse.
  assign w_enemy_new = w_hit[COL_ENEMY_HIT] & (startOfFrame | ~r_enemy_counted);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_enemy_counted <= 1'b0;
      enemy_hit_count <= '0;
    end else begin
      r_enemy_counted <= startOfFrame ? w_hit[COL_ENEMY_HIT]
                                      : (r_enemy_counted | w_hit[COL_ENEMY_HIT]);
      if (clear_count)
        enemy_hit_count <= '0;
      else if (w_enemy_new && (enemy_hit_count != {COUNT_WIDTH{1'b1}}))
        enemy_hit_count <= enemy_hit_count + COUNT_WIDTH'(1);
    end
  end

endmodule
